// File: rtl/usb_fx2_rx_stream.sv
// usb_fx2_rx_stream
// Read-side controller for the FX2 synchronous slave FIFO (OUT endpoint).
// Pulls 16-bit words off the USB data bus into a small skid FIFO and
// presents them as a valid/ready stream framed into FRAME_WORDS-word frames.
//
// Ports:
//   USB_IFCLK, RST_N        - interface clock, async active-low reset
//   enable, clr             - read enable, synchronous flush
//   usb_data_i, usb_flaga   - FX2 data bus and OUT-not-empty flag
//   usb_addr, usb_slrd_n,
//   usb_sloe_n              - FX2 FIFOADR / SLRD / SLOE (strobes registered)
//   m_data, m_valid,
//   m_ready, m_last         - output stream, m_last marks last frame word
//   frame_done              - pulse the cycle after the last word is popped
//
// Optional: define USB_RX_CHECKSUM_EN to add frame_sum / sum_valid, the
// modulo-2^16 sum of each frame's words, presented with frame_done.
module usb_fx2_rx_stream #(
  parameter logic [1:0] EP_ADDR     = 2'b00,
  parameter int         DEPTH       = 4,
  parameter int         FRAME_WORDS = 784
) (
  input  logic        USB_IFCLK,
  input  logic        RST_N,
  input  logic        enable,
  input  logic        clr,
  input  logic [15:0] usb_data_i,
  input  logic        usb_flaga,
  output logic [1:0]  usb_addr,
  output logic        usb_slrd_n,
  output logic        usb_sloe_n,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        frame_done
`ifdef USB_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        sum_valid
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, ARM, READ} state_t;

  state_t          state, state_nxt;
  logic            slrd_nxt, sloe_nxt;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic [IW-1:0]   idx;
  logic            push, pop, last_idx;

  assign usb_addr = EP_ADDR;
  assign m_valid  = (count != '0);
  assign m_data   = mem[rd_ptr];
  assign last_idx = (idx == IW'(FRAME_WORDS - 1));
  assign m_last   = m_valid & last_idx;

  // A word is taken on the edge where SLRD was already low and the flag is
  // still up; clr wins over both push and pop.
  assign push      = ~usb_slrd_n & usb_flaga & ~clr;
  assign pop       = m_valid & m_ready & ~clr;
  assign count_nxt = clr ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && usb_flaga) state_nxt = ARM;
      // One turnaround cycle with SLOE low before SLRD; dropping enable
      // here must not start a read.
      ARM:     state_nxt = enable ? READ : IDLE;
      READ:    if (!enable) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
    sloe_nxt = (state_nxt == IDLE);
    // Look-ahead on the post-edge count so SLRD is never low while full.
    slrd_nxt = !((state_nxt == READ) && usb_flaga && (count_nxt < (AW+1)'(DEPTH)));
  end

  always_ff @(posedge USB_IFCLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      usb_slrd_n <= 1'b1;
      usb_sloe_n <= 1'b1;
    end else begin
      state      <= state_nxt;
      usb_slrd_n <= slrd_nxt;
      usb_sloe_n <= sloe_nxt;
    end
  end

  always_ff @(posedge USB_IFCLK) begin
    if (push) mem[wr_ptr] <= usb_data_i;
  end

  always_ff @(posedge USB_IFCLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      count      <= count_nxt;
      frame_done <= pop & last_idx;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        idx    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
          idx    <= last_idx ? '0 : idx + IW'(1);
        end
      end
    end
  end

`ifdef USB_RX_CHECKSUM_EN
  logic [15:0] acc;

  always_ff @(posedge USB_IFCLK or negedge RST_N) begin
    if (!RST_N) begin
      acc       <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= pop & last_idx;
      if (clr) begin
        acc <= '0;
      end else if (pop) begin
        if (last_idx) begin
          frame_sum <= acc + m_data;
          acc       <= '0;
        end else begin
          acc <= acc + m_data;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_usb_fx2_rx_stream.sv
module tb_usb_fx2_rx_stream;
  localparam int DEPTH = 4;
  localparam int FW    = 784;

  logic        USB_IFCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0, clr = 1'b0, usb_flaga = 1'b0, m_ready = 1'b0;
  logic [15:0] usb_data_i = '0;
  logic [1:0]  usb_addr;
  logic        usb_slrd_n, usb_sloe_n, m_valid, m_last, frame_done;
  logic [15:0] m_data;
`ifdef USB_RX_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic        sum_valid;
`endif

  usb_fx2_rx_stream #(.EP_ADDR(2'b00), .DEPTH(DEPTH), .FRAME_WORDS(FW)) dut (
    .USB_IFCLK(USB_IFCLK), .RST_N(RST_N), .enable(enable), .clr(clr),
    .usb_data_i(usb_data_i), .usb_flaga(usb_flaga), .usb_addr(usb_addr),
    .usb_slrd_n(usb_slrd_n), .usb_sloe_n(usb_sloe_n), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .frame_done(frame_done)
`ifdef USB_RX_CHECKSUM_EN
    , .frame_sum(frame_sum), .sum_valid(sum_valid)
`endif
  );

  always #5 USB_IFCLK = ~USB_IFCLK;

  int total = 0, bad = 0;

  // Reference model: FX2 endpoint presents words in order and advances only
  // when a word is actually read; the stream is just that queue in order.
  logic [15:0] q[$];
  int          idx, pops;
  bit          exp_fd, p_clr, p_en, p_fl;
  logic [15:0] bus_val;
  logic [15:0] acc, exp_fsum;
  bit          exp_sv;

  task automatic model_clear();
    q.delete();
    idx = 0; exp_fd = 0; acc = 0; exp_sv = 0;
  endtask

  // One clock: compare outputs with the model, drive next inputs, advance model.
  task automatic step(input bit en, input bit fl, input bit rdy, input bit cl);
    bit push, pop, last;
    total++;
    if (m_valid !== (q.size() != 0)) begin
      bad++; $display("FAIL m_valid got=%b exp=%b", m_valid, q.size() != 0);
    end
    if (q.size() != 0) begin
      total++;
      if (m_data !== q[0]) begin
        bad++; $display("FAIL m_data got=%h exp=%h", m_data, q[0]);
      end
    end
    total++;
    if (m_last !== (q.size() != 0 && idx == FW-1)) begin
      bad++; $display("FAIL m_last got=%b exp=%b idx=%0d", m_last, q.size() != 0 && idx == FW-1, idx);
    end
    total++;
    if (frame_done !== exp_fd) begin
      bad++; $display("FAIL frame_done got=%b exp=%b", frame_done, exp_fd);
    end
    total++;
    if (usb_addr !== 2'b00) begin
      bad++; $display("FAIL usb_addr got=%b exp=00", usb_addr);
    end
    if (usb_slrd_n === 1'b0) begin
      total++;
      if (usb_sloe_n !== 1'b0 || q.size() >= DEPTH) begin
        bad++; $display("FAIL slrd_ok sloe_n=%b fill=%0d (need sloe_n=0 fill<%0d)", usb_sloe_n, q.size(), DEPTH);
      end
    end
    if (p_clr || !p_en || !p_fl) begin
      total++;
      if (usb_slrd_n !== 1'b1) begin
        bad++; $display("FAIL slrd_blocked got=%b exp=1", usb_slrd_n);
      end
    end
    if (p_clr) begin
      total++;
      if (usb_sloe_n !== 1'b1 || m_valid !== 1'b0) begin
        bad++; $display("FAIL after_clr sloe_n=%b m_valid=%b exp 1/0", usb_sloe_n, m_valid);
      end
    end
`ifdef USB_RX_CHECKSUM_EN
    total++;
    if (sum_valid !== exp_sv) begin
      bad++; $display("FAIL sum_valid got=%b exp=%b", sum_valid, exp_sv);
    end
    if (exp_sv) begin
      total++;
      if (frame_sum !== exp_fsum) begin
        bad++; $display("FAIL frame_sum got=%h exp=%h", frame_sum, exp_fsum);
      end
    end
`endif
    enable = en; usb_flaga = fl; m_ready = rdy; clr = cl; usb_data_i = bus_val;
    push = (usb_slrd_n === 1'b0) && fl;
    pop  = (q.size() != 0) && rdy;
    if (cl) model_clear();
    else begin
      last   = pop && idx == FW-1;
      exp_fd = last;
      exp_sv = last;
      if (pop) begin
        if (last) begin exp_fsum = acc + q[0]; acc = 0; end
        else acc = acc + q[0];
        void'(q.pop_front());
        pops++;
        idx = last ? 0 : idx + 1;
      end
      if (push) begin q.push_back(bus_val); bus_val++; end
    end
    p_clr = cl; p_en = en; p_fl = fl;
    @(posedge USB_IFCLK); @(negedge USB_IFCLK);
  endtask

  task automatic do_reset();
    @(negedge USB_IFCLK);
    RST_N = 1'b0; enable = 0; clr = 0; usb_flaga = 0; m_ready = 0;
    repeat (2) @(negedge USB_IFCLK);
    model_clear();
    pops = 0; p_clr = 1; p_en = 0; p_fl = 0;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus_val = 16'h1111;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0);
      total++;
      if (usb_sloe_n !== 1'b1 || usb_slrd_n !== 1'b1 || m_valid !== 1'b0) begin
        bad++; $display("FAIL idle sloe_n=%b slrd_n=%b m_valid=%b exp 1/1/0", usb_sloe_n, usb_slrd_n, m_valid);
      end
    end
  endtask

`ifdef USB_RX_CHECKSUM_EN
  task automatic test_checksum();
    int seen;
    do_reset();
    bus_val = 16'd1; seen = 0;
    for (int i = 0; i < 800; i++) begin
      step(1, 1, 1, 0);
      if (sum_valid === 1'b1) begin
        seen++; total++;
        if (frame_sum !== 16'hB208 || frame_done !== 1'b1) begin
          bad++; $display("FAIL sum_1to784 got=%h fd=%b exp=b208 fd=1", frame_sum, frame_done);
        end
      end
    end
    total++;
    if (seen != 1) begin bad++; $display("FAIL sum_pulses got=%0d exp=1", seen); end
  endtask
`endif

  task automatic test_stream();
    int first_oe, first_rd, nfd;
    do_reset();
    bus_val = 16'($urandom);
    first_oe = -1; first_rd = -1; nfd = 0;
    for (int k = 1; k <= 1600; k++) begin
      step(1, 1, 1, 0);
      if (usb_sloe_n === 1'b0 && first_oe < 0) first_oe = k;
      if (usb_slrd_n === 1'b0 && first_rd < 0) first_rd = k;
      if (frame_done === 1'b1) nfd++;
    end
    total++;
    if (first_oe != 1 || first_rd != 2) begin
      bad++; $display("FAIL oe_before_rd oe=%0d rd=%0d exp 1/2", first_oe, first_rd);
    end
    total++;
    if (pops != 1597) begin bad++; $display("FAIL throughput got=%0d exp=1597", pops); end
    total++;
    if (nfd != 2) begin bad++; $display("FAIL frames_done got=%0d exp=2", nfd); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 20; i++) step(1, 1, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    total++;
    if (q.size() != DEPTH || usb_slrd_n !== 1'b1 || m_valid !== 1'b1) begin
      bad++; $display("FAIL backpressure fill=%0d slrd_n=%b m_valid=%b exp %0d/1/1", q.size(), usb_slrd_n, m_valid, DEPTH);
    end
    for (int i = 0; i < 50; i++) step(1, 1, 1, 0);
  endtask

  task automatic test_flag_drop();
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0);
    total++;
    if (usb_slrd_n !== 1'b1 || m_valid !== 1'b0) begin
      bad++; $display("FAIL flag_low slrd_n=%b m_valid=%b exp 1/0", usb_slrd_n, m_valid);
    end
    step(1, 1, 1, 0);
    total++;
    if (usb_slrd_n !== 1'b0) begin bad++; $display("FAIL flag_resume slrd_n=%b exp=0", usb_slrd_n); end
    for (int i = 0; i < 30; i++) step(1, 1, 1, 0);
  endtask

  task automatic test_clr();
    int n;
    n = 0;
    while (idx != 300 && n < 2000) begin step(1, 1, 1, 0); n++; end
    total++;
    if (idx != 300) begin bad++; $display("FAIL reach_300 idx=%0d exp=300", idx); end
    step(1, 1, 1, 1);
    total++;
    if (m_valid !== 1'b0 || usb_slrd_n !== 1'b1 || usb_sloe_n !== 1'b1) begin
      bad++; $display("FAIL clr m_valid=%b slrd_n=%b sloe_n=%b exp 0/1/1", m_valid, usb_slrd_n, usb_sloe_n);
    end
    for (int i = 0; i < 800; i++) step(1, 1, 1, 0);
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (idx != 500 && n < 2000) begin step(1, 1, 1, 0); n++; end
    #2 RST_N = 1'b0;
    #1;
    total++;
    if (m_valid !== 1'b0 || usb_slrd_n !== 1'b1 || usb_sloe_n !== 1'b1 || m_last !== 1'b0 || frame_done !== 1'b0) begin
      bad++; $display("FAIL async_reset m_valid=%b slrd_n=%b sloe_n=%b last=%b fd=%b exp 0/1/1/0/0",
                      m_valid, usb_slrd_n, usb_sloe_n, m_last, frame_done);
    end
    @(negedge USB_IFCLK);
    model_clear();
    p_clr = 1; p_en = 0; p_fl = 0;
    RST_N = 1'b1;
    for (int i = 0; i < 900; i++) step(1, 1, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++)
      step($urandom_range(9, 0) != 0, $urandom_range(9, 0) < 7,
           $urandom_range(9, 0) < 6, $urandom_range(99, 0) == 0);
  endtask

  initial begin
    test_reset();
`ifdef USB_RX_CHECKSUM_EN
    test_checksum();
`endif
    test_stream();
    test_backpressure();
    test_flag_drop();
    test_clr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/usb_fx2_rx_stream.md
Name: usb_fx2_rx_stream

Overview:
Read-side controller for the FX2 synchronous slave FIFO (OUT endpoint, host to FPGA) on the USB_IFCLK domain. It pulls 16-bit words from the USB data bus and buffers them in a small FIFO. It then presents them as a valid/ready stream, framed into fixed-length CNN input frames, to the downstream input-buffer/conv stage.

Parameters:
EP_ADDR, 2'b00, FIFOADR value driven while reading (EP2 OUT)
DEPTH, 4, skid FIFO entries (power of 2, >=4)
FRAME_WORDS, 784, words per frame (28x28 image, 16-bit pixel each)

Ports:
USB_IFCLK  input  1  FX2 interface clock; the only clock, all logic on its rising edge
RST_N  input  1  asynchronous active-low reset
enable  input  1  allow reads from FX2
clr  input  1  synchronous flush: FIFO emptied, frame index zeroed, state to IDLE
usb_data_i  input  16  USB_DATA bus, input direction
usb_flaga  input  1  FLAGA, high = OUT endpoint not empty
usb_addr  output  2  FIFOADR
usb_slrd_n  output  1  SLRD, active-low, registered
usb_sloe_n  output  1  SLOE, active-low, registered
m_data  output  16  stream word (FIFO head)
m_valid  output  1  m_data valid
m_ready  input  1  downstream accepts
m_last  output  1  head word is frame word FRAME_WORDS-1
frame_done  output  1  one-cycle pulse after the last word of a frame is accepted

Behaviour:
- Reset (RST_N low, async): state IDLE, usb_slrd_n=1, usb_sloe_n=1, usb_addr=EP_ADDR, FIFO empty, m_valid=0, m_last=0, frame_done=0, word index=0.
- State machine: IDLE -> ARM when enable and usb_flaga. ARM holds for one cycle with usb_sloe_n=0 (bus turnaround), then goes to READ. READ -> IDLE when enable=0 or clr.
- usb_sloe_n=0 in ARM and READ, otherwise 1. usb_addr=EP_ADDR at all times.
- usb_slrd_n next value: 0 iff next state is READ, usb_flaga=1 and next FIFO count < DEPTH. The next count includes this cycle's push and pop.
- Capture: at a rising edge where the registered usb_slrd_n==0 and usb_flaga==1, usb_data_i is pushed. Latency from bus to m_valid is 1 cycle.
- With continuous m_ready=1 and usb_flaga=1, throughput is 1 word/cycle with no bubbles.
- FIFO full: no push possible; the SLRD rule guarantees no capture while full. A capture while full is an internal error and must never occur.
- Simultaneous push and pop at a FIFO boundary: count unchanged, order preserved, no loss.
- usb_flaga falling mid-burst: a word on that edge is not captured. usb_slrd_n goes high the next cycle. State stays READ and resumes when the flag returns.
- enable deasserted mid-burst: no new SLRD assertion. A capture already committed on that edge still completes. Buffered words still drain to m_*.
- Pop = m_valid & m_ready. Word index increments per pop and wraps from FRAME_WORDS-1 to 0.
- m_last = m_valid & (index == FRAME_WORDS-1). frame_done pulses on the cycle after the pop of the last word.
- m_data/m_valid hold stable while m_valid & !m_ready.
- clr has priority over push and pop in the same cycle. The next cycle shows usb_slrd_n=1, usb_sloe_n=1 and m_valid=0.
- Reset asserted mid-frame: all state cleared immediately. The partial frame is discarded.

Optional Feature:
USB_RX_CHECKSUM_EN
- Defined: adds outputs frame_sum[15:0] and sum_valid.
- frame_sum = modulo-2^16 sum of all words popped in the frame, accumulating from 0.
- sum_valid pulses together with frame_done, with frame_sum valid and held until the next frame's first pop. The accumulator resets on reset, clr, and frame wrap.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset/idle: RST_N=0 then 1 with enable=0 and flaga=1 -> slrd_n=1, sloe_n=1, m_valid=0, addr=00 indefinitely.
- Streaming: enable=1, flaga=1, bus increments by 1 each cycle, m_ready=1 -> sloe_n low 1 cycle before slrd_n; m_data is a gap-free consecutive sequence; m_last on the 784th word; frame_done on the next cycle; the index wraps and the next frame starts cleanly.
- Backpressure: m_ready=0 for 10 cycles mid-burst -> exactly DEPTH=4 words buffered, slrd_n high, no word lost or duplicated after m_ready returns.
- Flag drop: flaga 1 -> 0 at 6000 ns -> no capture on any edge with flaga=0; the stream stays contiguous; reads resume when flaga=1.
- clr and reset mid-frame: clr at word 300 -> FIFO empty next cycle and index 0, so the next accepted word is index 0. RST_N low at word 500 -> outputs take reset values asynchronously.
- USB_RX_CHECKSUM_EN: one frame of words 1..784 -> frame_sum = 307720 mod 65536 = 45576 (0xB208), with sum_valid coincident with frame_done.
